// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store writeback stage: funct3 codes, FSM states,
// byte-enable masks and the size helpers used by the datapath.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_WB
  } lsu_state_e;

  // funct3[1:0] encodes the access size for both loads and stores
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return MASK_B;
      2'd1:    return MASK_H;
      2'd2:    return MASK_W;
      default: return MASK_D;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load alignment: shifts the addressed lane down to bit 0 and
// sign/zero-extends it according to the RV64 load funct3.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] raw;

  // Bytes above the dword boundary shift in as zero before extension
  always_comb begin
    raw  = rdata >> {off, 3'b000};
    data = raw;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){raw[7]}},   raw[7:0]};
      F3_LH:   data = {{(XLEN-16){raw[15]}}, raw[15:0]};
      F3_LW:   data = {{(XLEN-32){raw[31]}}, raw[31:0]};
      F3_LBU:  data = {{(XLEN-8){1'b0}},     raw[7:0]};
      F3_LHU:  data = {{(XLEN-16){1'b0}},    raw[15:0]};
      F3_LWU:  data = {{(XLEN-32){1'b0}},    raw[31:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/lsu_wb.sv
// Memory/writeback stage feeding the integer register file write port.
// Optional build macro LSU_MISALIGN_TRAP_EN adds a misaligned-access pulse output.
module lsu_wb
  import lsu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_is_load,
  input  logic            in_is_store,
  input  logic [2:0]      in_funct3,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_reg_wen,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_store_data,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  output logic            mem_req_wen,
  output logic [XLEN-1:0] mem_req_wdata,
  output logic [7:0]      mem_req_wmask,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_rdata,
  output logic [RD_W-1:0] rd,
  output logic [XLEN-1:0] rd_wdata,
  output logic            reg_wen,
  output logic            busy
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic            misaligned
`endif
);

  lsu_state_e      state, next_state;
  logic            op_load;
  logic [2:0]      op_funct3;
  logic [RD_W-1:0] op_rd;
  logic            op_wen;
  logic [XLEN-1:0] op_addr;
  logic [XLEN-1:0] op_sdata;
  logic            accept;
  logic            in_mem;
  logic            trap;
  logic [2:0]      off;
  logic [XLEN-1:0] load_data;

  assign accept   = in_valid && (state == ST_IDLE);
  assign in_mem   = in_is_load || in_is_store;
  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign off      = op_addr[2:0];

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = in_mem && is_misaligned(in_funct3[1:0], in_addr[2:0]);
`else
  assign trap = 1'b0;
`endif

  lsu_load_align #(.XLEN(XLEN)) u_align (
    .rdata  (mem_rsp_rdata),
    .off    (off),
    .funct3 (op_funct3),
    .data   (load_data)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Trapped memory ops take the non-memory path so the pulse lands at N+1
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (in_valid) next_state = (in_mem && !trap) ? ST_REQ : ST_WB;
      ST_REQ:  if (mem_req_ready) next_state = ST_WAIT;
      ST_WAIT: if (mem_rsp_valid) next_state = op_load ? ST_WB : ST_IDLE;
      ST_WB:   next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_req_wen   = 1'b0;
    mem_req_wdata = '0;
    mem_req_wmask = '0;
    if (state == ST_REQ) begin
      mem_req_valid = 1'b1;
      mem_req_addr  = {op_addr[XLEN-1:3], 3'b000};
      mem_req_wen   = !op_load;
      mem_req_wdata = op_sdata << {off, 3'b000};
      mem_req_wmask = size_mask(op_funct3[1:0]) << off;
    end
  end

  // rd/rd_wdata only move when a write is actually going to pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      op_load   <= 1'b0;
      op_funct3 <= '0;
      op_rd     <= '0;
      op_wen    <= 1'b0;
      op_addr   <= '0;
      op_sdata  <= '0;
      rd        <= '0;
      rd_wdata  <= '0;
      reg_wen   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misaligned <= 1'b0;
`endif
    end else begin
      reg_wen <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misaligned <= 1'b0;
`endif
      if (accept) begin
        op_load   <= in_is_load;
        op_funct3 <= in_funct3;
        op_rd     <= in_rd;
        op_wen    <= in_reg_wen;
        op_addr   <= in_addr;
        op_sdata  <= in_store_data;
        if (!in_mem && in_reg_wen && (in_rd != '0)) begin
          reg_wen  <= 1'b1;
          rd       <= in_rd;
          rd_wdata <= in_addr;
        end
`ifdef LSU_MISALIGN_TRAP_EN
        if (trap) misaligned <= 1'b1;
`endif
      end
      if ((state == ST_WAIT) && mem_rsp_valid && op_load && op_wen && (op_rd != '0)) begin
        reg_wen  <= 1'b1;
        rd       <= op_rd;
        rd_wdata <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_lsu_wb.sv
// Directed self-checking bench for lsu_wb: ALU writeback, load/store lane handling,
// handshake stalls, reset during a transaction and the optional misalign trap.
module tb_lsu_wb;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_is_load, in_is_store, in_reg_wen;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic [63:0] in_addr, in_store_data;
  logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid;
  logic [63:0] mem_req_addr, mem_req_wdata, mem_rsp_rdata;
  logic [7:0]  mem_req_wmask;
  logic [4:0]  rd;
  logic [63:0] rd_wdata;
  logic        reg_wen, busy;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  int assertCount = 0;
  int failCount   = 0;

  always #5 clock = ~clock;

  lsu_wb #(.XLEN(64), .RD_W(5)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_is_load    (in_is_load),
    .in_is_store   (in_is_store),
    .in_funct3     (in_funct3),
    .in_rd         (in_rd),
    .in_reg_wen    (in_reg_wen),
    .in_addr       (in_addr),
    .in_store_data (in_store_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wen   (mem_req_wen),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wmask (mem_req_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .rd            (rd),
    .rd_wdata      (rd_wdata),
    .reg_wen       (reg_wen),
    .busy          (busy)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .misaligned    (misaligned)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Presents one op for a single accepting cycle and returns in cycle N+1
  task automatic applyStimulus(input logic isLoad, input logic isStore, input logic [2:0] f3,
                               input logic [4:0] rdIdx, input logic wen,
                               input logic [63:0] addr, input logic [63:0] sdata);
    in_valid      = 1'b1;
    in_is_load    = isLoad;
    in_is_store   = isStore;
    in_funct3     = f3;
    in_rd         = rdIdx;
    in_reg_wen    = wen;
    in_addr       = addr;
    in_store_data = sdata;
    step();
    in_valid = 1'b0;
  endtask

  task automatic memCycle(input int readyDelay, input int rspDelay, input logic [63:0] rdata);
    repeat (readyDelay) step();
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    repeat (rspDelay) step();
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = rdata;
    step();
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0; in_funct3 = '0;
    in_rd = '0; in_reg_wen = 1'b0; in_addr = '0; in_store_data = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    step();
    step();
    checkOutput("reset in_ready", in_ready, 1'b1);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset reg_wen", reg_wen, 1'b0);
    checkOutput("reset mem_req_valid", mem_req_valid, 1'b0);
    checkOutput("reset mem_req_wmask", mem_req_wmask, 8'h00);
    checkOutput("reset rd_wdata", rd_wdata, 64'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    checkOutput("reset misaligned", misaligned, 1'b0);
`endif
    reset = 1'b0;
    step();

    // ALU op to x5
    applyStimulus(1'b0, 1'b0, 3'b000, 5'd5, 1'b1, 64'h1234, 64'h0);
    checkOutput("alu reg_wen", reg_wen, 1'b1);
    checkOutput("alu rd", rd, 5'd5);
    checkOutput("alu rd_wdata", rd_wdata, 64'h1234);
    checkOutput("alu in_ready in WB", in_ready, 1'b0);
    step();
    checkOutput("alu reg_wen pulse end", reg_wen, 1'b0);
    checkOutput("alu back to idle", in_ready, 1'b1);

    // ALU op to x0 is suppressed and outputs hold
    applyStimulus(1'b0, 1'b0, 3'b000, 5'd0, 1'b1, 64'h5555, 64'h0);
    checkOutput("x0 reg_wen", reg_wen, 1'b0);
    checkOutput("x0 rd_wdata hold", rd_wdata, 64'h1234);
    checkOutput("x0 rd hold", rd, 5'd5);
    step();

    // LB at offset 3
    applyStimulus(1'b1, 1'b0, 3'b000, 5'd7, 1'b1, 64'h8000_0003, 64'h0);
    checkOutput("lb req valid", mem_req_valid, 1'b1);
    checkOutput("lb req addr", mem_req_addr, 64'h8000_0000);
    checkOutput("lb req wen", mem_req_wen, 1'b0);
    memCycle(0, 0, 64'h0000_0000_8000_0000);
    checkOutput("lb reg_wen", reg_wen, 1'b1);
    checkOutput("lb rd", rd, 5'd7);
    checkOutput("lb rd_wdata", rd_wdata, 64'hFFFF_FFFF_FFFF_FF80);
    step();

    // LBU same address
    applyStimulus(1'b1, 1'b0, 3'b100, 5'd8, 1'b1, 64'h8000_0003, 64'h0);
    memCycle(0, 0, 64'h0000_0000_8000_0000);
    checkOutput("lbu rd_wdata", rd_wdata, 64'h80);
    step();

    // SH at offset 6, rd/reg_wen set but stores never write back
    applyStimulus(1'b0, 1'b1, 3'b001, 5'd9, 1'b1, 64'h8000_0006, 64'hABCD);
    checkOutput("sh req wen", mem_req_wen, 1'b1);
    checkOutput("sh req addr", mem_req_addr, 64'h8000_0000);
    checkOutput("sh wmask", mem_req_wmask, 8'hC0);
    checkOutput("sh wdata", mem_req_wdata, 64'hABCD_0000_0000_0000);
    memCycle(0, 0, 64'h0);
    checkOutput("sh no reg_wen", reg_wen, 1'b0);
    checkOutput("sh idle after ack", in_ready, 1'b1);
    checkOutput("sh rd_wdata hold", rd_wdata, 64'h80);
    step();
    checkOutput("sh still no reg_wen", reg_wen, 1'b0);

    // Both flags set behaves as a load
    applyStimulus(1'b1, 1'b1, 3'b010, 5'd6, 1'b1, 64'h44, 64'hDEAD);
    checkOutput("ld+st wen", mem_req_wen, 1'b0);
    memCycle(0, 0, 64'h8765_4321_0000_0000);
    checkOutput("lw off4 sign", rd_wdata, 64'hFFFF_FFFF_8765_4321);
    step();
    applyStimulus(1'b1, 1'b0, 3'b110, 5'd6, 1'b1, 64'h44, 64'h0);
    memCycle(1, 1, 64'h8765_4321_0000_0000);
    checkOutput("lwu off4 zero", rd_wdata, 64'h0000_0000_8765_4321);
    step();

    // Handshake stall: ready low 3 cycles, response 2 cycles after acceptance
    applyStimulus(1'b1, 1'b0, 3'b011, 5'd10, 1'b1, 64'h1000_0010, 64'h0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall req valid", mem_req_valid, 1'b1);
      checkOutput("stall req addr", mem_req_addr, 64'h1000_0010);
      checkOutput("stall req wen", mem_req_wen, 1'b0);
      checkOutput("stall in_ready", in_ready, 1'b0);
      step();
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    checkOutput("wait req dropped", mem_req_valid, 1'b0);
    checkOutput("wait no reg_wen", reg_wen, 1'b0);
    step();
    checkOutput("wait busy", busy, 1'b1);
    checkOutput("wait in_ready", in_ready, 1'b0);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 64'h0123_4567_89AB_CDEF;
    step();
    mem_rsp_valid = 1'b0;
    checkOutput("ld reg_wen", reg_wen, 1'b1);
    checkOutput("ld rd", rd, 5'd10);
    checkOutput("ld rd_wdata", rd_wdata, 64'h0123_4567_89AB_CDEF);
    step();
    checkOutput("ld single pulse", reg_wen, 1'b0);
    checkOutput("ld idle", in_ready, 1'b1);

    // Back-to-back ALU ops: one accept every two cycles
    in_valid = 1'b1; in_is_load = 1'b0; in_is_store = 1'b0;
    in_rd = 5'd3; in_reg_wen = 1'b1; in_addr = 64'h77;
    step();
    checkOutput("b2b first wen", reg_wen, 1'b1);
    checkOutput("b2b in_ready low", in_ready, 1'b0);
    in_addr = 64'h88;
    step();
    checkOutput("b2b gap wen", reg_wen, 1'b0);
    step();
    in_valid = 1'b0;
    checkOutput("b2b second data", rd_wdata, 64'h88);
    step();

    // Reset while waiting for a response, then a stale response
    applyStimulus(1'b1, 1'b0, 3'b000, 5'd11, 1'b1, 64'h20, 64'h0);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("rst in_ready", in_ready, 1'b1);
    checkOutput("rst req valid", mem_req_valid, 1'b0);
    checkOutput("rst reg_wen", reg_wen, 1'b0);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 64'hFF;
    step();
    mem_rsp_valid = 1'b0;
    checkOutput("stale rsp reg_wen", reg_wen, 1'b0);
    checkOutput("stale rsp busy", busy, 1'b0);
    step();
    checkOutput("stale rsp reg_wen later", reg_wen, 1'b0);

`ifdef LSU_MISALIGN_TRAP_EN
    applyStimulus(1'b1, 1'b0, 3'b010, 5'd12, 1'b1, 64'h102, 64'h0);
    checkOutput("trap misaligned", misaligned, 1'b1);
    checkOutput("trap no req", mem_req_valid, 1'b0);
    checkOutput("trap no reg_wen", reg_wen, 1'b0);
    step();
    checkOutput("trap pulse end", misaligned, 1'b0);
    checkOutput("trap idle", in_ready, 1'b1);
    checkOutput("trap still no req", mem_req_valid, 1'b0);
`else
    // Accesses crossing the dword boundary lose their upper bytes
    applyStimulus(1'b1, 1'b0, 3'b010, 5'd12, 1'b1, 64'h306, 64'h0);
    memCycle(0, 0, 64'hBEEF_0000_0000_0000);
    checkOutput("lw off6 truncated", rd_wdata, 64'hBEEF);
    step();
    applyStimulus(1'b1, 1'b0, 3'b001, 5'd13, 1'b1, 64'h307, 64'h0);
    memCycle(0, 0, 64'h80EF_0000_0000_0000);
    checkOutput("lh off7 truncated", rd_wdata, 64'h0080);
    step();
    applyStimulus(1'b0, 1'b1, 3'b010, 5'd0, 1'b0, 64'h306, 64'h1122_3344);
    checkOutput("sw off6 wmask", mem_req_wmask, 8'hC0);
    checkOutput("sw off6 wdata", mem_req_wdata, 64'h3344_0000_0000_0000);
    memCycle(0, 0, 64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
